// File: rtl/yarvi_trace_buf_if.sv
// Retire-record channel: one trace record per cycle qualified by valid,
// with a ready signal flowing back from the receiver.
interface yarvi_trace_buf_if #(
    parameter int unsigned XLEN = 64
);
    logic            valid;
    logic            ready;
    logic [1:0]      prv;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            we;
    logic [4:0]      addr;
    logic [63:0]     d;

    modport master (output valid, prv, pc, insn, we, addr, d, input ready);
    modport slave  (input valid, prv, pc, insn, we, addr, d, output ready);
endinterface

// File: rtl/yarvi_trace_buf.sv
// Retirement-trace capture buffer for the yarvi core.
// Stream mode: lossy FIFO with a saturating drop counter.
// Ring mode: circular logic-analyser buffer armed by a pulse, triggered on a
// PC match, capturing a fixed post-trigger window and then freezing.
module yarvi_trace_buf #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DEPTH_LG2 = 4,
    parameter int unsigned POST_TRIG = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                arm,
    input  logic                trig_en,
    input  logic [XLEN-1:0]     trig_pc,
    yarvi_trace_buf_if.slave    ret,
    yarvi_trace_buf_if.master   out,
    output logic [DEPTH_LG2:0]  count,
    output logic [31:0]         dropped,
    output logic [1:0]          state
);
    localparam int unsigned        DEPTH     = 1 << DEPTH_LG2;
    localparam logic [DEPTH_LG2:0] FULL      = (DEPTH_LG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LG2:0] POST_LAST = (DEPTH_LG2 + 1)'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_FROZEN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]      prv;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            we;
        logic [4:0]      addr;
        logic [63:0]     d;
    } rec_t;

    rec_t                 mem_q [DEPTH];
    rec_t                 mem_d [DEPTH];
    rec_t                 rec_in;
    state_e               state_q, state_d;
    logic                 mode_q;
    logic [DEPTH_LG2-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [DEPTH_LG2:0]   count_q, count_d;
    logic [DEPTH_LG2:0]   post_q, post_d;
    logic [31:0]          dropped_q, dropped_d;
    logic                 out_valid_q, out_valid_d;
    logic                 push, pop;

    assign rec_in = {ret.prv, ret.pc, ret.insn, ret.we, ret.addr, ret.d};

    // Next-state logic for pointers, occupancy, capture FSM and storage.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        count_d   = count_q;
        post_d    = post_q;
        dropped_d = dropped_q;
        mem_d     = mem_q;
        push      = 1'b0;
        pop       = out_valid_q && out.ready;

        if (!mode_q) begin
            // A pop in the same cycle frees the slot the new record takes.
            push = ret.valid && (count_q != FULL || pop);
            if (ret.valid && !push && dropped_q != '1)
                dropped_d = dropped_q + 32'd1;
            if (pop)
                rd_d = rd_q + 1'b1;
            if (push)
                wr_d = wr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end else if (arm) begin
            state_d = S_CAPTURE;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            post_d  = '0;
        end else begin
            unique case (state_q)
                S_CAPTURE, S_POST: begin
                    if (ret.valid) begin
                        push = 1'b1;
                        wr_d = wr_q + 1'b1;
                        // Full ring: the oldest entry is overwritten, head advances.
                        if (count_q == FULL)
                            rd_d = rd_q + 1'b1;
                        else
                            count_d = count_q + 1'b1;
                        if (state_q == S_CAPTURE) begin
                            if (trig_en && ret.pc == trig_pc) begin
                                post_d  = '0;
                                state_d = (POST_TRIG == 0) ? S_FROZEN : S_POST;
                            end
                        end else begin
                            post_d = post_q + 1'b1;
                            if (post_d == POST_LAST)
                                state_d = S_FROZEN;
                        end
                    end
                end
                S_FROZEN: begin
                    if (pop) begin
                        rd_d    = rd_q + 1'b1;
                        count_d = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (push)
            mem_d[wr_q] = rec_in;

        out_valid_d = (count_d != '0) && (!mode_q || state_d == S_FROZEN);
    end

    // Register update; reset latches the capture mode and clears everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q      <= mode;
            state_q     <= mode ? S_IDLE : S_CAPTURE;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            post_q      <= '0;
            dropped_q   <= '0;
            out_valid_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            dropped_q   <= dropped_d;
            out_valid_q <= out_valid_d;
            mem_q       <= mem_d;
        end
    end

    // Capture never back-pressures the core.
    assign ret.ready = 1'b1;

    assign out.valid = out_valid_q;
    assign out.prv   = mem_q[rd_q].prv;
    assign out.pc    = mem_q[rd_q].pc;
    assign out.insn  = mem_q[rd_q].insn;
    assign out.we    = mem_q[rd_q].we;
    assign out.addr  = mem_q[rd_q].addr;
    assign out.d     = mem_q[rd_q].d;

    assign count   = count_q;
    assign dropped = dropped_q;
    assign state   = state_q;
endmodule
